// File: rtl/harq_pkg.sv
// harq_pkg: shared state encoding, default widths and lane saturation for the HARQ send path.
package harq_pkg;
  localparam int DEF_LANES = 16;
  localparam int DEF_IN_W  = 10;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_AW    = 11;
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_READ  = 5'b00010,
    S_DRAIN = 5'b00100,
    S_DONE  = 5'b01000
  } state_e;
  function automatic int sat_lane(input int v, input int ow);
    int hi;
    int lo;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction
endpackage

// File: rtl/harq_send_ctrl_if.sv
// harq_send_ctrl_if: control handshake, combine-buffer read port and output stream of the send stage.
interface harq_send_ctrl_if #(
  parameter int LANES = harq_pkg::DEF_LANES,
  parameter int IN_W  = harq_pkg::DEF_IN_W,
  parameter int OUT_W = harq_pkg::DEF_OUT_W,
  parameter int AW    = harq_pkg::DEF_AW
) ();
  logic                   i_abort;
  logic                   i_req;
  logic                   i_pingpong;
  logic [15:0]            i_ncb;
  logic                   o_rd_en;
  logic [AW-1:0]          o_rd_addr;
  logic                   o_rd_sel;
  logic [LANES*IN_W-1:0]  i_rd_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [LANES*OUT_W-1:0] o_data;
  logic                   o_last;
  logic                   o_comp;
  logic                   o_busy;
  modport slave (
    input  i_abort, i_req, i_pingpong, i_ncb, i_rd_data, i_ready,
    output o_rd_en, o_rd_addr, o_rd_sel, o_valid, o_data, o_last, o_comp, o_busy
  );
  modport master (
    output i_abort, i_req, i_pingpong, i_ncb, i_rd_data, i_ready,
    input  o_rd_en, o_rd_addr, o_rd_sel, o_valid, o_data, o_last, o_comp, o_busy
  );
endinterface

// File: rtl/harq_send_skid.sv
// harq_send_skid: 2-entry output FIFO of {last, data}; its head register is the registered stream output.
module harq_send_skid #(
  parameter int W = 129
) (
  input  logic         i_core_clk,
  input  logic         i_rx_rstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   occ_o
);
  logic [W-1:0] m0_q, m0_d, m1_q, m1_d;
  logic [1:0]   cnt_q, cnt_d, lvl;
  // lvl is the fill after this cycle's pop; the pushed word lands in the first free slot
  always_comb begin
    lvl   = cnt_q - {1'b0, pop_i};
    m0_d  = (push_i && lvl == 2'd0) ? data_i : (pop_i ? m1_q : m0_q);
    m1_d  = (push_i && lvl == 2'd1) ? data_i : m1_q;
    cnt_d = flush_i ? 2'd0 : lvl + {1'b0, push_i};
  end
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      m0_q  <= '0;
      m1_q  <= '0;
      cnt_q <= '0;
    end else begin
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      cnt_q <= cnt_d;
    end
  end
  assign valid_o = |cnt_q;
  assign data_o  = m0_q;
  assign occ_o   = cnt_q;
endmodule

// File: rtl/harq_send_ctrl.sv
// harq_send_ctrl: reads combined soft words from the ping/pong buffer, saturates lanes and streams them out.
// Define HARQ_SEND_TAIL_ZERO_EN to zero lanes beyond i_ncb[3:0] in the final word.
module harq_send_ctrl
  import harq_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int AW    = DEF_AW
) (
  input logic             i_core_clk,
  input logic             i_rx_rstn,
  harq_send_ctrl_if.slave bus
);
  localparam int DW = LANES * OUT_W;
  state_e          state_q, state_d;
  logic [AW:0]     nw_q, nw_d, nw_req;
  logic [AW-1:0]   addr_q, addr_d;
  logic            sel_q, sel_d;
  logic            infl_q, infl_last_q;
  logic            issue, last_addr, pop, sk_valid;
  logic [1:0]      occ;
  logic [12:0]     nw_raw;
  logic [DW-1:0]   lane_w;
  logic [DW:0]     sk_out;
  assign nw_raw    = {1'b0, bus.i_ncb[15:4]} + {12'd0, |bus.i_ncb[3:0]};
  assign nw_req    = (nw_raw > 13'(1 << AW)) ? (AW+1)'(1 << AW) : (AW+1)'(nw_raw);
  assign last_addr = {1'b0, addr_q} == nw_q - (AW+1)'(1);
  assign pop       = sk_valid & bus.i_ready;
  // credit counts the word leaving this cycle so a steady i_ready sustains one word per cycle
  assign issue     = state_q == S_READ && !bus.i_abort &&
                     ({1'b0, occ} - {2'b0, pop} + {2'b0, infl_q}) < 3'd2;
  always_comb begin
    state_d = state_q;
    nw_d    = nw_q;
    sel_d   = sel_q;
    addr_d  = (state_q == S_READ) ? addr_q + AW'(issue) : '0;
    case (state_q)
      S_IDLE:  if (bus.i_req) begin
                 nw_d    = nw_req;
                 sel_d   = bus.i_pingpong;
                 state_d = (nw_req == '0) ? S_DONE : S_READ;
               end
      S_READ:  state_d = (issue && last_addr) ? S_DRAIN : S_READ;
      S_DRAIN: state_d = (pop && sk_out[DW]) ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    if (bus.i_abort) begin
      state_d = S_IDLE;
      sel_d   = sel_q;
      nw_d    = nw_q;
    end
  end
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q     <= S_IDLE;
      nw_q        <= '0;
      addr_q      <= '0;
      sel_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nw_q        <= nw_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      infl_q      <= issue;
      infl_last_q <= issue & last_addr;
    end
  end
`ifdef HARQ_SEND_TAIL_ZERO_EN
  logic [3:0] tail_q;
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) tail_q <= '0;
    else if (state_q == S_IDLE && bus.i_req) tail_q <= bus.i_ncb[3:0];
  end
`endif
  always_comb begin
    lane_w = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_w[k*OUT_W +: OUT_W] = OUT_W'(sat_lane(int'($signed(bus.i_rd_data[k*IN_W +: IN_W])), OUT_W));
`ifdef HARQ_SEND_TAIL_ZERO_EN
      if (infl_last_q && tail_q != 4'd0 && k >= int'(tail_q)) lane_w[k*OUT_W +: OUT_W] = '0;
`endif
    end
  end
  harq_send_skid #(.W(DW + 1)) u_skid (
    .i_core_clk(i_core_clk),
    .i_rx_rstn (i_rx_rstn),
    .push_i    (infl_q),
    .pop_i     (pop),
    .flush_i   (bus.i_abort),
    .data_i    ({infl_last_q, lane_w}),
    .valid_o   (sk_valid),
    .data_o    (sk_out),
    .occ_o     (occ)
  );
  assign bus.o_rd_en   = issue;
  assign bus.o_rd_addr = addr_q;
  assign bus.o_rd_sel  = sel_q;
  assign bus.o_valid   = sk_valid;
  assign bus.o_data    = sk_out[DW-1:0];
  assign bus.o_last    = sk_out[DW];
  assign bus.o_comp    = state_q == S_DONE && !bus.i_abort;
  assign bus.o_busy    = state_q != S_IDLE;
endmodule

// File: tb/tb_harq_send_ctrl.sv
// tb_harq_send_ctrl: vector table plus corner sequences; a scoreboard queue holds the expected output words.
module tb_harq_send_ctrl;
  import harq_pkg::*;
  localparam int LANES = DEF_LANES;
  localparam int IN_W  = DEF_IN_W;
  localparam int OUT_W = DEF_OUT_W;
  localparam int AW    = DEF_AW;
  localparam int DW    = LANES * OUT_W;
  localparam int MAXV  = 2 ** (OUT_W - 1) - 1;
  localparam int MINV  = -(2 ** (OUT_W - 1));

  typedef struct {
    logic [15:0] ncb;
    logic        pp;
    int          mode;
    int          nw;
    int          comp_lat;
    int          valid_lat;
  } vec_t;
  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   chk = 0;
  int   errs = 0;
  int   mode = 0;
  int   cur_nw, rd_exp, words_rx, first_v, comp_cnt, comp_cyc, comp_base, t0;
  logic stall_p = 1'b0;
  logic [DW-1:0] data_p;
  logic last_p;
  exp_t sbq[$];

  harq_send_ctrl_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) bus ();
  harq_send_ctrl #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) dut (
    .i_core_clk(clk),
    .i_rx_rstn (rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lane_val(input int i);
    case (i)
      0:       return 300;
      1:       return -300;
      2:       return 127;
      3:       return -128;
      4:       return 128;
      5:       return -129;
      6:       return 0;
      7:       return 1;
      8:       return -1;
      9:       return 511;
      10:      return -512;
      default: return 55;
    endcase
  endfunction

  function automatic logic [LANES*IN_W-1:0] mk_in(input logic sel, input int a);
    logic [LANES*IN_W-1:0] w;
    for (int k = 0; k < LANES; k++) w[k*IN_W +: IN_W] = IN_W'(lane_val((a * 3 + k + (sel ? 5 : 0)) % 12));
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic sel, input int a);
    logic [DW-1:0] w;
    int v;
    for (int k = 0; k < LANES; k++) begin
      v = lane_val((a * 3 + k + (sel ? 5 : 0)) % 12);
      v = (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
      w[k*OUT_W +: OUT_W] = OUT_W'(v);
    end
    return w;
  endfunction

  // combine buffer model: one-cycle read latency
  always @(posedge clk) if (bus.o_rd_en) bus.i_rd_data <= mk_in(bus.o_rd_sel, int'(bus.o_rd_addr));

  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_ready = (mode == 0) ? 1'b1 :
                    (mode == 1) ? ((cyc % 16 < 10) ? (cyc % 2 == 0) : (cyc % 16 == 10)) :
                    1'($urandom_range(0, 1));
    end
  end

  task automatic chk_eq(input string nm, input int got, input int want);
    chk++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.o_rd_en) begin
          chk++;
          if (int'(bus.o_rd_addr) != rd_exp || rd_exp >= cur_nw) begin
            errs++;
            $display("FAIL rd_addr got %0d want %0d (nw %0d)", bus.o_rd_addr, rd_exp, cur_nw);
          end
          rd_exp++;
        end
        if (bus.o_comp) begin
          comp_cnt++;
          comp_cyc = cyc;
        end
        if (bus.o_valid && first_v < 0) first_v = cyc;
        if (stall_p) begin
          chk++;
          if (!bus.o_valid || bus.o_data !== data_p || bus.o_last !== last_p) begin
            errs++;
            $display("FAIL stall_hold got v%0b l%0b %h want v1 l%0b %h", bus.o_valid, bus.o_last, bus.o_data, last_p, data_p);
          end
        end
        stall_p = bus.o_valid && !bus.i_ready;
        data_p  = bus.o_data;
        last_p  = bus.o_last;
        if (bus.o_valid && bus.i_ready) begin
          words_rx++;
          chk++;
          if (sbq.size() == 0) begin
            errs++;
            $display("FAIL word unexpected got %h", bus.o_data);
          end else begin
            e = sbq.pop_front();
            if (bus.o_data !== e.d || bus.o_last !== e.l) begin
              errs++;
              $display("FAIL word%0d got l%0b %h want l%0b %h", words_rx - 1, bus.o_last, bus.o_data, e.l, e.d);
            end
          end
        end
      end else stall_p = 1'b0;
    end
  endtask

  task automatic start(input logic [15:0] ncb, input logic pp, input int nw);
    exp_t e;
    for (int w = 0; w < nw; w++) begin
      e.d = exp_word(pp, w);
      e.l = (w == nw - 1);
`ifdef HARQ_SEND_TAIL_ZERO_EN
      if (e.l && ncb[3:0] != 4'd0)
        for (int k = int'(ncb[3:0]); k < LANES; k++) e.d[k*OUT_W +: OUT_W] = '0;
`endif
      sbq.push_back(e);
    end
    cur_nw = nw;
    rd_exp = 0;
    words_rx = 0;
    first_v = -1;
    comp_base = comp_cnt;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.i_req = 1'b1;
    bus.i_ncb = ncb;
    bus.i_pingpong = pp;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    chk_eq("busy_t1", int'(bus.o_busy), 1);
    chk_eq("rd_sel_t1", int'(bus.o_rd_sel), int'(pp));
    chk_eq("rd_en_t1", int'(bus.o_rd_en), int'(nw != 0));
    chk_eq("rd_addr_t1", int'(bus.o_rd_addr), 0);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (comp_cnt == comp_base && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk++;
    if (comp_cnt == comp_base) begin
      errs++;
      $display("FAIL comp_timeout got none within %0d cycles want pulse", limit);
    end
  endtask

  task automatic run_row(input vec_t v);
    mode = v.mode;
    start(v.ncb, v.pp, v.nw);
    wait_done(v.nw * 4 + 100);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_eq("comp_count", comp_cnt - comp_base, 1);
    chk_eq("words_rx", words_rx, v.nw);
    chk_eq("sb_left", sbq.size(), 0);
    chk_eq("reads", rd_exp, v.nw);
    chk_eq("busy_end", int'(bus.o_busy), 0);
    if (v.comp_lat > 0) chk_eq("comp_lat", comp_cyc - t0, v.comp_lat);
    if (v.valid_lat > 0) chk_eq("valid_lat", first_v - t0, v.valid_lat);
    if (v.nw == 0) chk_eq("never_valid", first_v, -1);
    sbq.delete();
  endtask

  task automatic main_seq();
    vec_t tbl[8];
    int n;
    tbl[0] = '{16'd64,   1'b0, 0, 4,    7,    3};
    tbl[1] = '{16'd20,   1'b1, 0, 2,    5,    3};
    tbl[2] = '{16'd256,  1'b0, 1, 16,   0,    3};
    tbl[3] = '{16'd0,    1'b1, 0, 0,    1,    0};
    tbl[4] = '{16'd17,   1'b0, 2, 2,    0,    3};
    tbl[5] = '{16'd1,    1'b1, 0, 1,    4,    3};
    tbl[6] = '{16'hFFFF, 1'b0, 0, 2048, 2051, 3};
    tbl[7] = '{16'd48,   1'b1, 0, 3,    6,    3};
    bus.i_req = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_ncb = '0;
    bus.i_pingpong = 1'b0;
    rstn = 1'b0;
    comp_cnt = 0;
    cur_nw = 0;
    rd_exp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_rd_en", int'(bus.o_rd_en), 0);
    chk_eq("rst_rd_addr", int'(bus.o_rd_addr), 0);
    chk_eq("rst_valid", int'(bus.o_valid), 0);
    chk_eq("rst_busy", int'(bus.o_busy), 0);
    chk_eq("rst_comp", int'(bus.o_comp), 0);
    chk_eq("rst_data_nz", int'(|bus.o_data), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) run_row(tbl[i]);
    // repeated request mid-block is ignored
    mode = 0;
    start(16'd64, 1'b0, 4);
    @(posedge clk);
    #1;
    bus.i_req = 1'b1;
    bus.i_ncb = 16'd160;
    bus.i_pingpong = 1'b1;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    chk_eq("rereq_sel", int'(bus.o_rd_sel), 0);
    wait_done(200);
    repeat (10) @(posedge clk);
    chk_eq("rereq_comp", comp_cnt - comp_base, 1);
    chk_eq("rereq_words", words_rx, 4);
    chk_eq("rereq_sb", sbq.size(), 0);
    // abort part way through a 32-word block
    start(16'd512, 1'b0, 32);
    n = 0;
    while (words_rx < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("abort_progress", int'(words_rx >= 5), 1);
    @(posedge clk);
    #1;
    bus.i_abort = 1'b1;
    @(posedge clk);
    #1;
    bus.i_abort = 1'b0;
    chk_eq("abort_busy", int'(bus.o_busy), 0);
    chk_eq("abort_valid", int'(bus.o_valid), 0);
    chk_eq("abort_rd_en", int'(bus.o_rd_en), 0);
    sbq.delete();
    repeat (40) @(posedge clk);
    chk_eq("abort_no_comp", comp_cnt - comp_base, 0);
    run_row(tbl[7]);
    // asynchronous reset mid-stream
    start(16'd256, 1'b1, 16);
    n = 0;
    while (words_rx < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk_eq("arst_rd_en", int'(bus.o_rd_en), 0);
    chk_eq("arst_rd_addr", int'(bus.o_rd_addr), 0);
    chk_eq("arst_rd_sel", int'(bus.o_rd_sel), 0);
    chk_eq("arst_valid", int'(bus.o_valid), 0);
    chk_eq("arst_data_nz", int'(|bus.o_data), 0);
    chk_eq("arst_last", int'(bus.o_last), 0);
    chk_eq("arst_comp", int'(bus.o_comp), 0);
    chk_eq("arst_busy", int'(bus.o_busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    sbq.delete();
    run_row(tbl[0]);
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule
